// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: datapath width (`WORD), ALU op codes, drain FSM states.
`ifndef WORD
`define WORD 32
`endif

package ex_stage_pkg;

   localparam int WORD_W = `WORD;
   localparam int REG_W  = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } drain_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX, MEM/WB and EX/MEM signal bundle for the execute stage.
// No handshake: every cycle is an instruction slot; bubbles arrive as all-zero control.
interface ex_stage_if
   import ex_stage_pkg::*;
#(
   parameter int WIDTH = WORD_W
);
   logic               mem_w_in;
   logic               mem_r_in;
   logic               wb_en_in;
   logic               terminate_in;
   logic [3:0]         alu_op_in;
   logic [REG_W-1:0]   reg_rs_in;
   logic [REG_W-1:0]   reg_rt_in;
   logic [REG_W-1:0]   reg_dest_in;
   logic               alu_2_imm_in;
   logic [WIDTH-1:0]   alu_1_data_in;
   logic [WIDTH-1:0]   alu_2_data_in;
   logic [WIDTH-1:0]   st_data_in;

   logic               memwb_wb_en;
   logic [REG_W-1:0]   memwb_reg_dest;
   logic [WIDTH-1:0]   memwb_data;

   logic               mem_w_out;
   logic               mem_r_out;
   logic               wb_en_out;
   logic               terminate_out;
   logic [REG_W-1:0]   reg_dest_out;
   logic [WIDTH-1:0]   alu_result_out;
   logic [WIDTH-1:0]   st_data_out;
   logic               halt;
   logic               ovf;
   drain_state_e       dbg_state;

   modport master (
      output mem_w_in, mem_r_in, wb_en_in, terminate_in, alu_op_in,
             reg_rs_in, reg_rt_in, reg_dest_in, alu_2_imm_in,
             alu_1_data_in, alu_2_data_in, st_data_in,
             memwb_wb_en, memwb_reg_dest, memwb_data,
      input  mem_w_out, mem_r_out, wb_en_out, terminate_out, reg_dest_out,
             alu_result_out, st_data_out, halt, ovf, dbg_state
   );

   modport slave (
      input  mem_w_in, mem_r_in, wb_en_in, terminate_in, alu_op_in,
             reg_rs_in, reg_rt_in, reg_dest_in, alu_2_imm_in,
             alu_1_data_in, alu_2_data_in, st_data_in,
             memwb_wb_en, memwb_reg_dest, memwb_data,
      output mem_w_out, mem_r_out, wb_en_out, terminate_out, reg_dest_out,
             alu_result_out, st_data_out, halt, ovf, dbg_state
   );
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; overflow reports signed ADD/SUB overflow only.
module ex_alu
   import ex_stage_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_ovf
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [SHW-1:0]   w_shamt;
   logic             w_lt_s;
   logic             w_lt_u;

   assign w_sum   = i_a + i_b;
   assign w_diff  = i_a - i_b;
   assign w_shamt = i_a[SHW-1:0];
   assign w_lt_s  = $signed(i_a) < $signed(i_b);
   assign w_lt_u  = i_a < i_b;

   always_comb begin
      o_result = '0;
      o_ovf    = 1'b0;
      case (i_op)
         ALU_ADD: begin
            o_result = w_sum;
            o_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_SUB: begin
            o_result = w_diff;
            o_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
         end
         ALU_AND:  o_result = i_a & i_b;
         ALU_OR:   o_result = i_a | i_b;
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_NOR:  o_result = ~(i_a | i_b);
         ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_s};
         ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_u};
         ALU_SLL:  o_result = i_b << w_shamt;
         ALU_SRL:  o_result = i_b >> w_shamt;
         ALU_SRA:  o_result = $signed(i_b) >>> w_shamt;
         ALU_LUI:  o_result = i_b << 16;
         default:  o_result = '0;
      endcase
   end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM register and end-of-program drain FSM.
// Define EX_OVF_DETECT_EN to flag signed ADD/SUB overflow and suppress that instruction's writes.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int WIDTH        = WORD_W,
   parameter int DRAIN_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);
`ifdef EX_OVF_DETECT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic               r_mem_w;
   logic               r_mem_r;
   logic               r_wb_en;
   logic               r_term;
   logic [REG_W-1:0]   r_reg_dest;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_st_data;
   logic               r_halt;
   logic               r_ovf;
   logic [7:0]         r_cnt;
   drain_state_e       r_state;

   logic               w_exmem_ok;
   logic               w_memwb_ok;
   logic [WIDTH-1:0]   w_op_a;
   logic [WIDTH-1:0]   w_rt_val;
   logic [WIDTH-1:0]   w_op_b;
   logic [WIDTH-1:0]   w_st_val;
   logic [WIDTH-1:0]   w_alu_result;
   logic               w_alu_ovf;
   logic               w_ovf_kill;

   // A load's EX/MEM result is only an address, so it must never be forwarded.
   assign w_exmem_ok = r_wb_en && !r_mem_r && (r_reg_dest != '0);
   assign w_memwb_ok = bus.memwb_wb_en && (bus.memwb_reg_dest != '0);

   assign w_op_a = (w_exmem_ok && r_reg_dest == bus.reg_rs_in)         ? r_result       :
                   (w_memwb_ok && bus.memwb_reg_dest == bus.reg_rs_in) ? bus.memwb_data :
                                                                          bus.alu_1_data_in;

   assign w_rt_val = (w_exmem_ok && r_reg_dest == bus.reg_rt_in)         ? r_result       :
                     (w_memwb_ok && bus.memwb_reg_dest == bus.reg_rt_in) ? bus.memwb_data :
                                                                            bus.alu_2_data_in;

   assign w_st_val = (w_exmem_ok && r_reg_dest == bus.reg_rt_in)         ? r_result       :
                     (w_memwb_ok && bus.memwb_reg_dest == bus.reg_rt_in) ? bus.memwb_data :
                                                                            bus.st_data_in;

   assign w_op_b = bus.alu_2_imm_in ? bus.alu_2_data_in : w_rt_val;

   ex_alu #(.WIDTH(WIDTH)) u_alu (
      .i_op     (bus.alu_op_in),
      .i_a      (w_op_a),
      .i_b      (w_op_b),
      .o_result (w_alu_result),
      .o_ovf    (w_alu_ovf)
   );

   assign w_ovf_kill = OVF_EN && w_alu_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_w    <= 1'b0;
         r_mem_r    <= 1'b0;
         r_wb_en    <= 1'b0;
         r_term     <= 1'b0;
         r_reg_dest <= '0;
         r_result   <= '0;
         r_st_data  <= '0;
         r_halt     <= 1'b0;
         r_ovf      <= 1'b0;
         r_cnt      <= '0;
         r_state    <= ST_RUN;
      end else begin
         r_reg_dest <= bus.reg_dest_in;
         r_result   <= w_alu_result;
         r_st_data  <= w_st_val;
         case (r_state)
            ST_RUN: begin
               r_mem_w <= bus.mem_w_in && !w_ovf_kill;
               r_mem_r <= bus.mem_r_in;
               r_wb_en <= bus.wb_en_in && !w_ovf_kill;
               r_term  <= bus.terminate_in;
               if (w_ovf_kill) r_ovf <= 1'b1;
               if (bus.terminate_in) begin
                  if (DRAIN_CYCLES == 0) begin
                     r_state <= ST_HALTED;
                     r_halt  <= 1'b1;
                  end else begin
                     r_cnt   <= 8'(DRAIN_CYCLES);
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Instructions behind the terminate are squashed; extra terminates are ignored.
               r_mem_w <= 1'b0;
               r_mem_r <= 1'b0;
               r_wb_en <= 1'b0;
               r_term  <= 1'b0;
               if (r_cnt <= 8'd1) begin
                  r_cnt   <= '0;
                  r_state <= ST_HALTED;
                  r_halt  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_mem_w <= 1'b0;
               r_mem_r <= 1'b0;
               r_wb_en <= 1'b0;
               r_term  <= 1'b0;
               r_halt  <= 1'b1;
               r_state <= ST_HALTED;
            end
         endcase
      end
   end

   assign bus.mem_w_out      = r_mem_w;
   assign bus.mem_r_out      = r_mem_r;
   assign bus.wb_en_out      = r_wb_en;
   assign bus.terminate_out  = r_term;
   assign bus.reg_dest_out   = r_reg_dest;
   assign bus.alu_result_out = r_result;
   assign bus.st_data_out    = r_st_data;
   assign bus.halt           = r_halt;
   assign bus.ovf            = r_ovf;
   assign bus.dbg_state      = r_state;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed and random instructions against a behavioural model with a scoreboard queue.
module tb_ex_stage;
   localparam int W     = 32;
   localparam int DRAIN = 2;
`ifdef EX_OVF_DETECT_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct packed {
      logic        mem_w;
      logic        mem_r;
      logic        wb;
      logic        term;
      logic [4:0]  dest;
      logic [31:0] res;
      logic [31:0] st;
      logic        halt;
      logic        ovf;
   } out_t;

   typedef struct {
      logic        mem_w, mem_r, wb, term, imm;
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, st;
      logic        mwb_en;
      logic [4:0]  mwb_dest;
      logic [31:0] mwb_data;
   } instr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_stage_if #(.WIDTH(W)) bus ();

   ex_stage #(.WIDTH(W), .DRAIN_CYCLES(DRAIN)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   out_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // model state: last expected EX/MEM contents, cycles since terminate (-1 = none), sticky ovf
   out_t m_prev;
   int   m_since;
   logic m_ovf;

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa = int'(a);
      int sb = int'(b);
      int sh = int'(a[4:0]);
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return b << sh;
         4'd9:  return b >> sh;
         4'd10: return 32'(sb >>> sh);
         4'd11: return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint s;
      if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
      else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic logic [31:0] fwd(input out_t prev, input instr_t t, input logic [4:0] r,
                                       input logic [31:0] dflt);
      if (r != 5'd0 && prev.wb && !prev.mem_r && prev.dest == r) return prev.res;
      if (r != 5'd0 && t.mwb_en && t.mwb_dest == r) return t.mwb_data;
      return dflt;
   endfunction

   task automatic model_reset();
      m_prev  = '0;
      m_since = -1;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input instr_t t, output out_t e);
      logic        squash;
      logic [31:0] a, b;
      logic        ov;
      squash = (m_since >= 0);
      a  = fwd(m_prev, t, t.rs, t.a);
      b  = t.imm ? t.b : fwd(m_prev, t, t.rt, t.b);
      ov = OVF_EN && ref_ovf(t.op, a, b);
      e.dest = t.rd;
      e.res  = ref_alu(t.op, a, b);
      e.st   = fwd(m_prev, t, t.rt, t.st);
      if (squash) begin
         e.mem_w = 1'b0; e.mem_r = 1'b0; e.wb = 1'b0; e.term = 1'b0;
         m_since++;
      end else begin
         e.mem_w = t.mem_w && !ov;
         e.mem_r = t.mem_r;
         e.wb    = t.wb && !ov;
         e.term  = t.term;
         if (ov) m_ovf = 1'b1;
         if (t.term) m_since = 0;
      end
      e.halt = (m_since >= DRAIN);
      e.ovf  = m_ovf;
      m_prev = e;
   endtask

   task automatic drive(input instr_t t);
      bus.mem_w_in       = t.mem_w;
      bus.mem_r_in       = t.mem_r;
      bus.wb_en_in       = t.wb;
      bus.terminate_in   = t.term;
      bus.alu_op_in      = t.op;
      bus.reg_rs_in      = t.rs;
      bus.reg_rt_in      = t.rt;
      bus.reg_dest_in    = t.rd;
      bus.alu_2_imm_in   = t.imm;
      bus.alu_1_data_in  = t.a;
      bus.alu_2_data_in  = t.b;
      bus.st_data_in     = t.st;
      bus.memwb_wb_en    = t.mwb_en;
      bus.memwb_reg_dest = t.mwb_dest;
      bus.memwb_data     = t.mwb_data;
   endtask

   function automatic instr_t rand_instr();
      instr_t t;
      t.op       = 4'($urandom_range(0, 15));
      t.rs       = 5'($urandom_range(0, 7));
      t.rt       = 5'($urandom_range(0, 7));
      t.rd       = 5'($urandom_range(0, 7));
      t.a        = $urandom;
      t.b        = $urandom;
      t.st       = $urandom;
      t.mem_w    = 1'($urandom_range(0, 1));
      t.mem_r    = 1'($urandom_range(0, 1));
      t.wb       = 1'($urandom_range(0, 1));
      t.imm      = 1'($urandom_range(0, 1));
      t.term     = 1'b0;
      t.mwb_en   = 1'($urandom_range(0, 1));
      t.mwb_dest = 5'($urandom_range(0, 7));
      t.mwb_data = $urandom;
      return t;
   endfunction

   function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] a,
                                 input logic [4:0] rt, input logic [31:0] b, input logic [4:0] rd,
                                 input logic wb);
      instr_t t;
      t = '{default: '0};
      t.op = op; t.rs = rs; t.a = a; t.rt = rt; t.b = b; t.rd = rd; t.wb = wb;
      return t;
   endfunction

   task automatic issue(input instr_t t);
      out_t e;
      @(negedge clk);
      #1;
      rst = 1'b0;
      drive(t);
      model_step(t, e);
      exp_q.push_back(e);
   endtask

   // Reset with terminate_in held high: reset must win.
   task automatic do_reset(input int cycles);
      instr_t t;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         rst = 1'b1;
         t = rand_instr();
         t.term = 1'b1;
         drive(t);
         model_reset();
         exp_q.push_back(out_t'(0));
      end
   endtask

   out_t mon_got;
   out_t mon_exp;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_got.mem_w = bus.mem_w_out;
         mon_got.mem_r = bus.mem_r_out;
         mon_got.wb    = bus.wb_en_out;
         mon_got.term  = bus.terminate_out;
         mon_got.dest  = bus.reg_dest_out;
         mon_got.res   = bus.alu_result_out;
         mon_got.st    = bus.st_data_out;
         mon_got.halt  = bus.halt;
         mon_got.ovf   = bus.ovf;
         n_vec++;
         if (mon_got !== mon_exp) begin
            n_miss++;
            $display("FAIL exmem vec %0d: got mw=%0b mr=%0b wb=%0b term=%0b rd=%0d res=%h st=%h halt=%0b ovf=%0b | expected mw=%0b mr=%0b wb=%0b term=%0b rd=%0d res=%h st=%h halt=%0b ovf=%0b",
                     n_vec, mon_got.mem_w, mon_got.mem_r, mon_got.wb, mon_got.term, mon_got.dest,
                     mon_got.res, mon_got.st, mon_got.halt, mon_got.ovf,
                     mon_exp.mem_w, mon_exp.mem_r, mon_exp.wb, mon_exp.term, mon_exp.dest,
                     mon_exp.res, mon_exp.st, mon_exp.halt, mon_exp.ovf);
         end
      end
   end

   initial begin
      instr_t t;
      model_reset();
      do_reset(2);

      // plain ADD, no hazards: 5 + 7
      issue(mk(4'd0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd6, 1'b1));
      // back-to-back: r3 = 10, then r3 + r3 with stale 0 and MEM/WB r3 = 99
      issue(mk(4'd0, 5'd1, 32'd4, 5'd2, 32'd6, 5'd3, 1'b1));
      t = mk(4'd0, 5'd3, 32'd0, 5'd3, 32'd0, 5'd7, 1'b1);
      t.mwb_en = 1'b1; t.mwb_dest = 5'd3; t.mwb_data = 32'd99;
      issue(t);
      // store with immediate 8, st_data forwarded from MEM/WB r4 = 0xAB
      t = mk(4'd0, 5'd7, 32'd100, 5'd4, 32'd8, 5'd0, 1'b0);
      t.imm = 1'b1; t.mem_w = 1'b1;
      t.mwb_en = 1'b1; t.mwb_dest = 5'd4; t.mwb_data = 32'h0000_00AB;
      issue(t);
      // load to r5, then a reader of r5 must not see the forwarded address
      t = mk(4'd0, 5'd1, 32'd0, 5'd2, 32'h40, 5'd5, 1'b1);
      t.imm = 1'b1; t.mem_r = 1'b1;
      issue(t);
      issue(mk(4'd0, 5'd5, 32'd11, 5'd2, 32'd1, 5'd6, 1'b1));
      // write to r0, then a reader of r0 keeps its own operands
      issue(mk(4'd0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd0, 1'b1));
      issue(mk(4'd0, 5'd0, 32'd1, 5'd0, 32'd2, 5'd1, 1'b1));
      // signed overflow on ADD
      issue(mk(4'd0, 5'd1, 32'h7FFF_FFFF, 5'd2, 32'd1, 5'd9, 1'b1));
      issue(mk(4'd1, 5'd1, 32'h8000_0000, 5'd2, 32'd1, 5'd9, 1'b1));

      for (int i = 0; i < 300; i++) issue(rand_instr());

      // terminate followed by real writes, then idle past halt
      t = rand_instr(); t.term = 1'b1; t.wb = 1'b1;
      issue(t);
      for (int i = 0; i < 6; i++) begin
         t = rand_instr(); t.wb = 1'b1; t.mem_w = 1'b1;
         issue(t);
      end
      do_reset(1);
      // reset one cycle into the drain aborts it
      t = rand_instr(); t.term = 1'b1;
      issue(t);
      issue(rand_instr());
      do_reset(1);
      for (int i = 0; i < 6; i++) issue(rand_instr());
      // second terminate during drain is ignored
      t = rand_instr(); t.term = 1'b1;
      issue(t);
      issue(t);
      for (int i = 0; i < 4; i++) issue(rand_instr());
      do_reset(2);

      for (int i = 0; i < 100; i++) begin
         t = rand_instr();
         t.term = ($urandom_range(0, 39) == 0);
         issue(t);
      end

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain_timeout: %0d expected outputs left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; sits directly downstream of the ID/EX pipeline register and consumes all of its outputs.
- Resolves operand forwarding from its own EX/MEM register and from the MEM/WB stage, then computes the ALU result.
- Registers the result and control into the EX/MEM pipeline register, and sequences the end-of-program drain after a terminate instruction.

Parameters:
- WIDTH, 32, datapath width; must equal `WORD.
- DRAIN_CYCLES, 2, cycles after terminate leaves EX before halt asserts, covering the MEM and WB drain.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_w_in, mem_r_in, wb_en_in, terminate_in  in  1 each  control from ID/EX
- alu_op_in  in  4  ALU operation code
- reg_rs_in, reg_rt_in, reg_dest_in  in  5 each  source and destination register numbers
- alu_2_imm_in  in  1  1 means alu_2_data_in is an immediate and is never forwarded
- alu_1_data_in, alu_2_data_in, st_data_in  in  WIDTH each  operand values read in ID
- memwb_wb_en, memwb_reg_dest, memwb_data  in  1/5/WIDTH  MEM/WB write-back bus
- mem_w_out, mem_r_out, wb_en_out, terminate_out  out  1 each  EX/MEM control
- reg_dest_out  out  5  EX/MEM destination register
- alu_result_out, st_data_out  out  WIDTH each  EX/MEM data
- halt  out  1  sticky; program fully drained
- ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): every output and all internal state go to 0, including halt, ovf and the drain counter. Reset applied mid-drain aborts the drain.
- Latency: 1 cycle. Outputs change only on posedge.
- Forwarding for operand A (reg_rs_in):
  - Use alu_result_out if wb_en_out=1, mem_r_out=0, reg_dest_out!=0 and reg_dest_out==reg_rs_in.
  - Otherwise use memwb_data if memwb_wb_en=1, memwb_reg_dest!=0 and it matches.
  - Otherwise use alu_1_data_in.
  - EX/MEM has priority over MEM/WB.
- Operand B (reg_rt_in): same rule, but applied only when alu_2_imm_in=0.
- st_data: forwarded on a reg_rt_in match regardless of alu_2_imm_in.
- Register 0 is never forwarded.
- Load results in EX/MEM are not forwarded. The ID hazard unit inserts a bubble for load-use cases.
- ALU codes (unsigned 4-bit; result truncated to WIDTH, carries dropped):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned)
  - 8 SLL, 9 SRL, 10 SRA: B shifted by A[4:0]
  - 11 LUI: B<<16
  - 12–15: result 0
- Drain FSM, states RUN, DRAIN, HALTED:
  - RUN: terminate_in=1 at posedge → terminate_out<=1, counter<=DRAIN_CYCLES, go to DRAIN.
  - DRAIN: all inputs are squashed (mem_w_out, mem_r_out, wb_en_out, terminate_out <= 0; data still registered). Counter decrements each cycle; at 1 → HALTED.
  - HALTED: halt=1, squashing continues, until rst.
  - DRAIN_CYCLES=0: RUN → HALTED directly.
  - A second terminate_in during DRAIN is ignored.
- Simultaneous rst and terminate_in: rst wins.

Optional Feature:
- EX_OVF_DETECT_EN defined:
  - Signed overflow on ADD/SUB sets ovf (sticky until rst).
  - That instruction's wb_en_out and mem_w_out are forced to 0; the result is still registered.
- Undefined: ovf is tied to 0 and no squash occurs.

Decomposition:
- Shared package/constants file: ALU op codes (ALU_ADD..ALU_LUI), the drain state encodings, and `WORD.
- One sub-module, ex_alu: combinational, takes op, a, b and returns result and overflow.
- Forwarding muxes, EX/MEM register and drain FSM stay in ex_stage.

Test Plan:
- ADD, rs=1 data 5, rt=2 data 7, no hazards → next cycle alu_result_out=12, wb_en_out passes through.
- Back-to-back: instr1 writes r3=10. Instr2 ADD r3,r3 with stale data 0, and memwb writing r3=99 in the same cycle → result 20 (EX/MEM beats MEM/WB).
- Store with alu_2_imm_in=1 (imm 8), rt=4, memwb writes r4=0xAB → alu_result=A+8 and st_data_out=0xAB; B not forwarded.
- EX/MEM holds a load with reg_dest=5; next instruction reads r5 → no forward, uses alu_1_data_in. Also, reg_dest=0 with wb_en=1 → never forwarded.
- terminate_in=1, then two valid writes follow → terminate_out=1 for 1 cycle, following wb_en_out=0, halt=1 exactly 2 cycles later. Asserting rst during DRAIN → halt stays 0.
- With EX_OVF_DETECT_EN: ADD 0x7FFFFFFF+1 → ovf=1, wb_en_out=0, result 0x80000000. Without the macro → ovf=0, wb_en_out=1.
